// File: rtl/masked_pkg.sv
// Shared types and constants for the 2-share Boolean-masked arithmetic datapath.
package masked_pkg;

    localparam int NSHARES = 2;

    typedef struct packed {
        logic s0;
        logic s1;
    } share2_t;

    function automatic int pipe_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/masked_adder_pipe_dom_and.sv
// First-order DOM-indep AND gate: every partial product is registered before the share XOR,
// so domain-0 and domain-1 values never share a combinational cone.
module dom_and
    import masked_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  share2_t a,
    input  share2_t b,
    input  logic    r,
    output share2_t z
);

    logic t00, t01, t11, t10;

    always_ff @(posedge clk) begin
        if (rst) begin
            t00 <= 1'b0;
            t01 <= 1'b0;
            t11 <= 1'b0;
            t10 <= 1'b0;
        end else begin
            t00 <= a.s0 & b.s0;
            t01 <= (a.s0 & b.s1) ^ r;
            t11 <= a.s1 & b.s1;
            t10 <= (a.s1 & b.s0) ^ r;
        end
    end

    assign z = '{s0: t00 ^ t01, s1: t11 ^ t10};

endmodule

// File: rtl/masked_adder_pipe.sv
// Boolean-masked ripple adder/subtractor, one bit-slice per pipeline stage.
// Shares stay separated end to end; the output register holds the result shares.
module masked_adder_pipe
    import masked_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic                       i_sub,
    input  logic [WIDTH-1:0]           i_A0,
    input  logic [WIDTH-1:0]           i_A1,
    input  logic [WIDTH-1:0]           i_B0,
    input  logic [WIDTH-1:0]           i_B1,
    input  logic [NSHARES*WIDTH-1:0]   i_r,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_S0,
    output logic [WIDTH-1:0]           o_S1,
    output logic                       o_C0,
    output logic                       o_C1
);

    if (WIDTH < 2) begin : g_bad_width
        $error("masked_adder_pipe: WIDTH must be at least 2");
    end

    // Inverting only share 0 of B negates B without recombining; the +1 enters as carry-in share 0.
    logic [WIDTH-1:0] b0_in;
    logic [WIDTH:0]   c0;
    logic [WIDTH:0]   c1;
    logic [WIDTH-1:0] sum0;
    logic [WIDTH-1:0] sum1;
    logic [WIDTH-1:0] vld_pipe;

    assign b0_in = i_sub ? ~i_B0 : i_B0;
    assign c0[0] = i_sub;
    assign c1[0] = 1'b0;

    for (genvar k = 0; k < WIDTH; k++) begin : g_slice
        share2_t a_k, b_k, c_k, p_k, s_k, ab_z, pc_z;
        logic [1:0] s_sr [WIDTH-k];

        if (k == 0) begin : g_direct
            assign a_k = {i_A0[0], i_A1[0]};
            assign b_k = {b0_in[0], i_B1[0]};
        end else begin : g_delay
            // Operand shares for bit k wait k cycles so they meet the carry rippling in from below.
            logic [3:0] op_sr [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        op_sr[j] <= '0;
                    end
                end else begin
                    op_sr[0] <= {i_A0[k], i_A1[k], b0_in[k], i_B1[k]};
                    for (int j = 1; j < k; j++) begin
                        op_sr[j] <= op_sr[j-1];
                    end
                end
            end

            assign a_k = {op_sr[k-1][3], op_sr[k-1][2]};
            assign b_k = {op_sr[k-1][1], op_sr[k-1][0]};
        end

        assign c_k = {c0[k], c1[k]};
        assign p_k = a_k ^ b_k;
        assign s_k = p_k ^ c_k;

        dom_and u_and_ab (
            .clk (clk),
            .rst (rst),
            .a   (a_k),
            .b   (b_k),
            .r   (i_r[2*k]),
            .z   (ab_z)
        );

        dom_and u_and_pc (
            .clk (clk),
            .rst (rst),
            .a   (p_k),
            .b   (c_k),
            .r   (i_r[2*k+1]),
            .z   (pc_z)
        );

        assign c0[k+1] = ab_z.s0 ^ pc_z.s0;
        assign c1[k+1] = ab_z.s1 ^ pc_z.s1;

        // Sum bit k is ready WIDTH-k cycles before the final carry, so it is held that long.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < WIDTH - k; j++) begin
                    s_sr[j] <= '0;
                end
            end else begin
                s_sr[0] <= {s_k.s0, s_k.s1};
                for (int j = 1; j < WIDTH - k; j++) begin
                    s_sr[j] <= s_sr[j-1];
                end
            end
        end

        assign sum0[k] = s_sr[WIDTH-k-1][1];
        assign sum1[k] = s_sr[WIDTH-k-1][0];
    end

    // Valid walks alongside the slices; result registers only move when a real result lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            o_valid  <= 1'b0;
            o_S0     <= '0;
            o_S1     <= '0;
            o_C0     <= 1'b0;
            o_C1     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[WIDTH-2:0], i_valid};
            o_valid  <= vld_pipe[WIDTH-1];
            if (vld_pipe[WIDTH-1]) begin
                o_S0 <= sum0;
                o_S1 <= sum1;
                o_C0 <= c0[WIDTH];
                o_C1 <= c1[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_masked_adder_pipe.sv
// Scoreboard bench for masked_adder_pipe: random masks and randomness, plain-arithmetic reference.
module tb_masked_adder_pipe;

    localparam int WIDTH = 8;
    localparam int NOPS  = 200;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   i_valid = 1'b0;
    logic                   i_sub = 1'b0;
    logic [WIDTH-1:0]       i_A0 = '0;
    logic [WIDTH-1:0]       i_A1 = '0;
    logic [WIDTH-1:0]       i_B0 = '0;
    logic [WIDTH-1:0]       i_B1 = '0;
    logic [2*WIDTH-1:0]     i_r = '0;
    logic                   o_valid;
    logic [WIDTH-1:0]       o_S0;
    logic [WIDTH-1:0]       o_S1;
    logic                   o_C0;
    logic                   o_C1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        int               issue;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [WIDTH:0]   got_log[$];
    logic [WIDTH-1:0] last_s0 = '0;
    logic [31:0]      r_tmp;
    bit               r_rand = 1'b0;
    int               cyc = 0;
    int               checks = 0;
    int               passes = 0;

    masked_adder_pipe #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_sub   (i_sub),
        .i_A0    (i_A0),
        .i_A1    (i_A1),
        .i_B0    (i_B0),
        .i_B1    (i_B1),
        .i_r     (i_r),
        .o_valid (o_valid),
        .o_S0    (o_S0),
        .o_S1    (o_S1),
        .o_C0    (o_C0),
        .o_C1    (o_C1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fresh randomness every cycle, or all-zero when exercising the no-randomness case.
    always @(posedge clk) begin
        #1;
        r_tmp = $urandom;
        i_r = r_rand ? r_tmp[2*WIDTH-1:0] : '0;
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // Monitor: every presented result is unmasked and matched against the oldest expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("sum", 32'(o_S0 ^ o_S1), 32'(mon_e.s));
                check_output("carry", 32'(o_C0 ^ o_C1), 32'(mon_e.c));
                check_output("latency", cyc - mon_e.issue, WIDTH + 1);
                got_log.push_back({o_C0 ^ o_C1, o_S0 ^ o_S1});
                last_s0 = o_S0;
            end
        end
    end

    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sub, input logic [WIDTH-1:0] a0,
                                  input logic [WIDTH-1:0] b0);
        exp_t e;
        int   total;
        i_valid = 1'b1;
        i_sub   = sub;
        i_A0    = a0;
        i_A1    = a ^ a0;
        i_B0    = b0;
        i_B1    = b ^ b0;
        if (sub) begin
            total = int'(a) - int'(b);
            e.c   = (a >= b);
        end else begin
            total = int'(a) + int'(b);
            e.c   = (total >= (1 << WIDTH));
        end
        e.s     = WIDTH'(total);
        e.issue = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            check_output("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic rand_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        apply_stimulus(a, b, sub, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    logic [WIDTH-1:0] op_a [NOPS];
    logic [WIDTH-1:0] op_b [NOPS];
    logic             op_s [NOPS];
    int               base1, base2;
    logic [WIDTH-1:0] s0_first;

    initial begin
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_valid", 32'(o_valid), 0);
        check_output("reset_S0", 32'(o_S0), 0);
        check_output("reset_S1", 32'(o_S1), 0);
        check_output("reset_C", 32'({o_C0, o_C1}), 0);
        @(posedge clk);
        #1;

        // Directed corner cases, issued back to back.
        r_rand = 1'b1;
        rand_op(8'h5A, 8'h3C, 1'b0);
        rand_op(8'hFF, 8'h01, 1'b0);
        rand_op(8'h80, 8'h80, 1'b0);
        rand_op(8'h10, 8'h01, 1'b1);
        rand_op(8'h01, 8'h02, 1'b1);
        rand_op(8'hAA, 8'hAA, 1'b1);
        drain();

        // Reset while three operations are in flight; the valid offered during reset must be dropped.
        rand_op(8'h11, 8'h22, 1'b0);
        rand_op(8'h33, 8'h44, 1'b1);
        rand_op(8'h55, 8'h66, 1'b0);
        idle(2);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_A0    = 8'h77;
        i_B1    = 8'h12;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check_output("midreset_valid", 32'(o_valid), 0);
        check_output("midreset_S0", 32'(o_S0), 0);
        check_output("midreset_S1", 32'(o_S1), 0);
        check_output("midreset_C", 32'({o_C0, o_C1}), 0);
        idle(15);
        rand_op(8'hC3, 8'h7E, 1'b0);
        drain();

        // Streaming with random randomness, then the same operations with i_r held at zero.
        for (int i = 0; i < NOPS; i++) begin
            op_a[i] = WIDTH'($urandom);
            op_b[i] = WIDTH'($urandom);
            op_s[i] = 1'($urandom);
        end
        base1 = got_log.size();
        for (int i = 0; i < NOPS; i++) rand_op(op_a[i], op_b[i], op_s[i]);
        drain();
        r_rand = 1'b0;
        base2 = got_log.size();
        for (int i = 0; i < NOPS; i++) rand_op(op_a[i], op_b[i], op_s[i]);
        drain();
        check_output("stream_count", got_log.size() - base2, NOPS);
        if (got_log.size() - base2 == NOPS && base2 - base1 == NOPS) begin
            for (int i = 0; i < NOPS; i++)
                check_output("r_zero_match", 32'(got_log[base2+i]), 32'(got_log[base1+i]));
        end

        // Same operands under two different masks: unmasked result equal, share 0 different.
        apply_stimulus(8'h3C, 8'h5A, 1'b0, 8'h00, 8'h55);
        drain();
        s0_first = last_s0;
        apply_stimulus(8'h3C, 8'h5A, 1'b0, 8'h01, 8'h55);
        drain();
        checks++;
        if (s0_first != last_s0) passes++;
        else $display("[TB] FAIL share_independence: S0 0x%0h in both runs, expected differing shares", last_s0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
